// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit: one bit per cycle over XLEN cycles, then a sign-fix cycle.
// Divide-by-zero and signed overflow may bypass the iteration when EARLY_OUT is set.
module muldiv_unit #(
    parameter int unsigned XLEN      = 32,
    parameter bit          EARLY_OUT = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [4:0]      alu_op,
    input  logic [XLEN-1:0] alu_a,
    input  logic [XLEN-1:0] alu_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] alu_result
);

    localparam int unsigned CNT_W = $clog2(XLEN);

    localparam logic [2:0] OP_MUL    = 3'd0;
    localparam logic [2:0] OP_MULH   = 3'd1;
    localparam logic [2:0] OP_MULHSU = 3'd2;
    localparam logic [2:0] OP_MULHU  = 3'd3;
    localparam logic [2:0] OP_DIV    = 3'd4;
    localparam logic [2:0] OP_DIVU   = 3'd5;
    localparam logic [2:0] OP_REM    = 3'd6;
    localparam logic [2:0] OP_REMU   = 3'd7;

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [2:0]        r_op;
    logic              r_neg;
    logic              r_spec;
    logic [XLEN-1:0]   r_spec_res;
    logic [XLEN-1:0]   r_hi;
    logic [XLEN-1:0]   r_lo;
    logic [XLEN-1:0]   r_b;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_in_ready;
    logic              r_out_valid;
    logic [XLEN-1:0]   r_result;

    // Operand decode at acceptance time
    logic [2:0]        w_op_lo;
    logic              w_legal;
    logic              w_is_div;
    logic              w_a_s;
    logic              w_b_s;
    logic              w_a_neg;
    logic              w_b_neg;
    logic              w_neg;
    logic [XLEN-1:0]   w_a_mag;
    logic [XLEN-1:0]   w_b_mag;
    logic              w_div0;
    logic              w_ovf;
    logic              w_spec;
    logic [XLEN-1:0]   w_spec_res;
    logic              w_accept;
    logic              w_fast;

    assign w_op_lo  = alu_op[2:0];
    assign w_legal  = (alu_op[4:3] == 2'b10);
    assign w_is_div = w_op_lo[2];
    assign w_a_s    = (w_op_lo == OP_MULH) || (w_op_lo == OP_MULHSU) ||
                      (w_op_lo == OP_DIV)  || (w_op_lo == OP_REM);
    assign w_b_s    = (w_op_lo == OP_MULH) || (w_op_lo == OP_DIV) || (w_op_lo == OP_REM);
    assign w_a_neg  = w_a_s & alu_a[XLEN-1];
    assign w_b_neg  = w_b_s & alu_b[XLEN-1];
    assign w_a_mag  = w_a_neg ? (-alu_a) : alu_a;
    assign w_b_mag  = w_b_neg ? (-alu_b) : alu_b;
    // Remainder follows the dividend sign; quotient and product follow the sign xor
    assign w_neg    = (w_op_lo == OP_REM) ? w_a_neg : (w_a_neg ^ w_b_neg);
    assign w_div0   = w_legal & w_is_div & (alu_b == '0);
    assign w_ovf    = w_legal & ((w_op_lo == OP_DIV) || (w_op_lo == OP_REM)) &
                      (alu_a == {1'b1, {(XLEN-1){1'b0}}}) & (alu_b == '1);
    assign w_spec   = w_div0 | w_ovf;
    assign w_accept = (r_state == S_IDLE) & in_valid & ~flush;
    assign w_fast   = ~w_legal | (EARLY_OUT & w_spec);

    always_comb begin
        w_spec_res = '0;
        if (w_legal && w_div0) begin
            w_spec_res = w_op_lo[1] ? alu_a : '1;
        end else if (w_legal && w_ovf) begin
            w_spec_res = w_op_lo[1] ? '0 : alu_a;
        end
    end

    // One iteration step: shift-add multiply and restoring divide share r_hi/r_lo
    logic [XLEN:0]     w_sum;
    logic [XLEN:0]     w_shift;
    logic [XLEN:0]     w_diff;

    assign w_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : '0);
    assign w_shift = {r_hi, r_lo[XLEN-1]};
    assign w_diff  = w_shift - {1'b0, r_b};

    logic [2*XLEN-1:0] w_prod_fix;
    logic [XLEN-1:0]   w_quo_fix;
    logic [XLEN-1:0]   w_rem_fix;
    logic [XLEN-1:0]   w_fix_res;

    assign w_prod_fix = r_neg ? (-{r_hi, r_lo}) : {r_hi, r_lo};
    assign w_quo_fix  = r_neg ? (-r_lo) : r_lo;
    assign w_rem_fix  = r_neg ? (-r_hi) : r_hi;

    always_comb begin
        w_fix_res = '0;
        case (r_op)
            OP_MUL:                      w_fix_res = w_prod_fix[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: w_fix_res = w_prod_fix[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:             w_fix_res = w_quo_fix;
            OP_REM, OP_REMU:             w_fix_res = w_rem_fix;
            default:                     w_fix_res = '0;
        endcase
        if (r_spec) begin
            w_fix_res = r_spec_res;
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; flush overrides everything
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (in_valid) w_state_nxt = w_fast ? S_DONE : S_CALC;
            S_CALC: if (r_cnt == CNT_W'(XLEN - 1)) w_state_nxt = S_FIX;
            S_FIX:  w_state_nxt = S_DONE;
            S_DONE: if (out_ready) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
        if (flush) begin
            w_state_nxt = S_IDLE;
        end
    end

    // Output decode: next values of the registered outputs
    logic            w_in_ready_d;
    logic            w_out_valid_d;
    logic            w_res_load;
    logic [XLEN-1:0] w_res_d;

    always_comb begin
        w_in_ready_d  = (w_state_nxt == S_IDLE);
        w_out_valid_d = (w_state_nxt == S_DONE);
        w_res_load    = 1'b1;
        w_res_d       = '0;
        if (w_state_nxt == S_DONE) begin
            if (r_state == S_IDLE) begin
                w_res_d = w_spec_res;
            end else if (r_state == S_FIX) begin
                w_res_d = w_fix_res;
            end else begin
                w_res_load = 1'b0;
            end
        end
    end

    // Datapath and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op        <= '0;
            r_neg       <= 1'b0;
            r_spec      <= 1'b0;
            r_spec_res  <= '0;
            r_hi        <= '0;
            r_lo        <= '0;
            r_b         <= '0;
            r_cnt       <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_result    <= '0;
        end else begin
            if (w_accept) begin
                r_op       <= w_op_lo;
                r_neg      <= w_neg;
                r_spec     <= w_spec;
                r_spec_res <= w_spec_res;
                r_cnt      <= '0;
                r_hi       <= '0;
                r_lo       <= w_is_div ? w_a_mag : w_b_mag;
                r_b        <= w_is_div ? w_b_mag : w_a_mag;
            end else if (r_state == S_CALC) begin
                r_cnt <= r_cnt + CNT_W'(1);
                if (!r_op[2]) begin
                    r_hi <= w_sum[XLEN:1];
                    r_lo <= {w_sum[0], r_lo[XLEN-1:1]};
                end else if (!w_diff[XLEN]) begin
                    r_hi <= w_diff[XLEN-1:0];
                    r_lo <= {r_lo[XLEN-2:0], 1'b1};
                end else begin
                    r_hi <= w_shift[XLEN-1:0];
                    r_lo <= {r_lo[XLEN-2:0], 1'b0};
                end
            end
            r_in_ready  <= w_in_ready_d;
            r_out_valid <= w_out_valid_d;
            if (w_res_load) begin
                r_result <= w_res_d;
            end
        end
    end

    assign in_ready   = r_in_ready;
    assign out_valid  = r_out_valid;
    assign alu_result = r_result;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: arithmetic reference model plus per-cycle output comparison.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  alu_op;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] alu_result;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    muldiv_unit #(.XLEN(32), .EARLY_OUT(1'b1)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .alu_op     (alu_op),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .alu_result (alu_result)
    );

    always #5 clk = ~clk;

    // Reference arithmetic straight from the op definitions
    function automatic logic [31:0] model_res(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] up;
        longint      sp;
        int          sa;
        int          sb;
        bit          ovf;
        sa  = $signed(a);
        sb  = $signed(b);
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        if (op[4:3] != 2'b10) return 32'd0;
        case (op[2:0])
            3'd0: begin up = {32'd0, a} * {32'd0, b}; return up[31:0]; end
            3'd1: begin sp = longint'(sa) * longint'(sb); up = 64'(sp); return up[63:32]; end
            3'd2: begin sp = longint'(sa) * longint'({32'd0, b}); up = 64'(sp); return up[63:32]; end
            3'd3: begin up = {32'd0, a} * {32'd0, b}; return up[63:32]; end
            3'd4: begin if (b == 0) return 32'hFFFF_FFFF; if (ovf) return a; return 32'(sa / sb); end
            3'd5: begin if (b == 0) return 32'hFFFF_FFFF; return a / b; end
            3'd6: begin if (b == 0) return a; if (ovf) return 32'd0; return 32'(sa % sb); end
            default: begin if (b == 0) return a; return a % b; end
        endcase
    endfunction

    function automatic int model_lat(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        bit sdiv;
        sdiv = (op[2:0] == 3'd4) || (op[2:0] == 3'd6);
        if (op[4:3] != 2'b10) return 1;
        if (op[2] && b == 0) return 1;
        if (sdiv && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 34;
    endfunction

    // Transaction-level model: busy countdown, then result held until consumed
    logic        m_busy;
    logic        m_valid;
    int          m_cnt;
    logic [31:0] m_res;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy <= 1'b0; m_valid <= 1'b0; m_cnt <= 0; m_res <= '0;
        end else if (flush) begin
            m_busy <= 1'b0; m_valid <= 1'b0;
        end else if (m_busy) begin
            if (m_cnt == 1) begin m_busy <= 1'b0; m_valid <= 1'b1; end
            m_cnt <= m_cnt - 1;
        end else if (m_valid) begin
            if (out_ready) m_valid <= 1'b0;
        end else if (in_valid) begin
            m_res <= model_res(alu_op, alu_a, alu_b);
            if (model_lat(alu_op, alu_a, alu_b) == 1) m_valid <= 1'b1;
            else begin m_busy <= 1'b1; m_cnt <= model_lat(alu_op, alu_a, alu_b) - 1; end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        if (chk_en && rst_n) begin
            chk("cyc_out_valid", 32'(out_valid), 32'(m_valid));
            chk("cyc_in_ready", 32'(in_ready), 32'(!m_busy && !m_valid));
            chk("cyc_result", alu_result, m_valid ? m_res : 32'd0);
        end
    end

    // Issue one op, measure latency, check result, then consume it
    task automatic run_op(input string name, input logic [4:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
        int n;
        chk({name, "_model"}, model_res(op, a, b), exp);
        alu_op = op; alu_a = a; alu_b = b; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0; alu_a = '0; alu_b = '0; alu_op = '0;
        n = 1;
        while (!out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_latency"}, 32'(n), 32'(exp_lat));
        chk({name, "_result"}, alu_result, exp);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({name, "_idle"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        logic [31:0] held;
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        alu_op = '0; alu_a = '0; alu_b = '0;
        #12;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_result", alu_result, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        chk_en = 1'b1;
        @(negedge clk);

        run_op("mul",      5'b10000, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 34);
        run_op("mulh",     5'b10001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 34);
        run_op("mulhsu",   5'b10010, 32'h8000_0000, 32'h8000_0000, 32'hC000_0000, 34);
        run_op("mulhu",    5'b10011, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 34);
        run_op("mulhu_ff", 5'b10011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34);
        run_op("div",      5'b10100, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 34);
        run_op("rem",      5'b10110, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 34);
        run_op("div_nb",   5'b10100, 32'h0000_0007, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 34);
        run_op("rem_nb",   5'b10110, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 34);
        run_op("div_min1", 5'b10100, 32'h8000_0000, 32'h0000_0001, 32'h8000_0000, 34);
        run_op("divu",     5'b10101, 32'd100,       32'd7,         32'd14,        34);
        run_op("remu",     5'b10111, 32'd100,       32'd7,         32'd2,         34);
        run_op("remu_z",   5'b10111, 32'd7,         32'd0,         32'd7,         1);
        run_op("div_ovf",  5'b10100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
        run_op("rem_ovf",  5'b10110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1);
        run_op("divu_z",   5'b10101, 32'd5,         32'd0,         32'hFFFF_FFFF, 1);
        run_op("div_z",    5'b10100, 32'hFFFF_FFF0, 32'd0,         32'hFFFF_FFFF, 1);
        run_op("illegal",  5'b01010, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0000_0000, 1);

        // Backpressure: result held for 10 cycles
        alu_op = 5'b10000; alu_a = 32'd6; alu_b = 32'd9; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (40) @(negedge clk);
        held = alu_result;
        chk("bp_value", held, 32'd54);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bp_valid", 32'(out_valid), 32'd1);
            chk("bp_stable", alu_result, 32'd54);
            chk("bp_busy", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("bp_release_ready", 32'(in_ready), 32'd1);
        chk("bp_release_valid", 32'(out_valid), 32'd0);

        // Flush during CALC cycle 5
        alu_op = 5'b10101; alu_a = 32'd1000; alu_b = 32'd3; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush_ready", 32'(in_ready), 32'd1);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            chk("flush_no_valid", 32'(out_valid), 32'd0);
        end
        run_op("after_flush", 5'b10101, 32'd1000, 32'd3, 32'd333, 34);

        // Asynchronous reset pulse mid-CALC
        alu_op = 5'b10001; alu_a = 32'h7FFF_FFFF; alu_b = 32'h7FFF_FFFF; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (10) @(negedge clk);
        chk_en = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("arst_ready", 32'(in_ready), 32'd1);
        chk("arst_valid", 32'(out_valid), 32'd0);
        chk("arst_result", alu_result, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        chk_en = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            chk("arst_no_valid", 32'(out_valid), 32'd0);
        end
        run_op("after_rst", 5'b10001, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h3FFF_FFFF, 34);

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
